// File: rtl/fg_pulse_gen.sv
// Frame-grabber opto pulse transmitter: emits a programmable train of
// fixed-width pulses on fg_signal for self-testing the sync block.
module fg_pulse_gen #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [NUM_W-1:0] n_pulses,
    output logic             fg_signal,
    output logic             busy,
    output logic             done,
    output logic             cfg_error,
    output logic [NUM_W-1:0] pulse_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_ph_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_width;
    logic [NUM_W-1:0] r_npulses;
    logic [NUM_W-1:0] r_pcount;
    logic             r_fg;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic w_cfg_bad;
    logic w_more;

    assign w_cfg_bad = (width == '0) || (width >= period);
    // n_pulses==0 means continuous, so a wrapped pulse_count never ends the train
    assign w_more    = (r_npulses == '0) || (r_pcount < r_npulses);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ph_cnt  <= '0;
            r_period  <= '0;
            r_width   <= '0;
            r_npulses <= '0;
            r_pcount  <= '0;
            r_fg      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_ph_cnt <= '0;
                r_fg     <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfg_bad) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_period  <= period;
                                r_width   <= width;
                                r_npulses <= n_pulses;
                                r_pcount  <= NUM_W'(1);
                                r_ph_cnt  <= CNT_W'(1);
                                r_fg      <= 1'b1;
                                r_busy    <= 1'b1;
                                r_state   <= S_HIGH;
                            end
                        end
                    end
                    S_HIGH: begin
                        r_ph_cnt <= r_ph_cnt + CNT_W'(1);
                        if (r_ph_cnt == r_width) begin
                            r_fg    <= 1'b0;
                            r_state <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (r_ph_cnt == r_period) begin
                            if (w_more) begin
                                r_ph_cnt <= CNT_W'(1);
                                r_pcount <= r_pcount + NUM_W'(1);
                                r_fg     <= 1'b1;
                                r_state  <= S_HIGH;
                            end else begin
                                r_ph_cnt <= '0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_IDLE;
                            end
                        end else begin
                            r_ph_cnt <= r_ph_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_fg    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fg_signal   = r_fg;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_error   = r_cfg_err;
    assign pulse_count = r_pcount;

endmodule

// File: tb/tb_fg_pulse_gen.sv
// Self-checking bench for fg_pulse_gen: expected edge/strobe cycles are queued
// at stimulus time and matched against events recorded from the DUT.
module tb_fg_pulse_gen;

    logic        clock = 1'b0;
    logic        reset, start, abort;
    logic [31:0] period, width;
    logic [15:0] n_pulses;
    logic        fg_signal, busy, done, cfg_error;
    logic [15:0] pulse_count;

    logic        start4, abort4, fg4, busy4, done4, err4;
    logic [3:0]  n4, pc4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q_rise_exp[$], q_rise_obs[$];
    int q_fall_exp[$], q_fall_obs[$];
    int q_done_exp[$], q_done_obs[$];
    int q_err_exp[$],  q_err_obs[$];
    logic prev_fg = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fg_pulse_gen #(.CNT_W(32), .NUM_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .period(period), .width(width), .n_pulses(n_pulses),
        .fg_signal(fg_signal), .busy(busy), .done(done),
        .cfg_error(cfg_error), .pulse_count(pulse_count)
    );

    fg_pulse_gen #(.CNT_W(32), .NUM_W(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .abort(abort4),
        .period(period), .width(width), .n_pulses(n4),
        .fg_signal(fg4), .busy(busy4), .done(done4),
        .cfg_error(err4), .pulse_count(pc4)
    );

    // Event recorder for the main instance; cycle index = posedges seen so far
    always @(negedge clock) begin
        if (fg_signal && !prev_fg) q_rise_obs.push_back(cyc);
        if (!fg_signal && prev_fg) q_fall_obs.push_back(cyc);
        if (done)                  q_done_obs.push_back(cyc);
        if (cfg_error)             q_err_obs.push_back(cyc);
        prev_fg = fg_signal;
    end

    task automatic clear_q();
        q_rise_exp.delete(); q_rise_obs.delete();
        q_fall_exp.delete(); q_fall_obs.delete();
        q_done_exp.delete(); q_done_obs.delete();
        q_err_exp.delete();  q_err_obs.delete();
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        period = '0; width = '0; n_pulses = '0;
        start4 = 1'b0; abort4 = 1'b0; n4 = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({fg_signal, busy, done, cfg_error} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {fg_signal, busy, done, cfg_error});
        end
        total++;
        if (pulse_count !== 16'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", pulse_count);
        end
        total++;
        if ({fg4, busy4, done4, err4, pc4} !== 8'h00) begin
            bad++; $display("FAIL reset_dut4 got=%h exp=00", {fg4, busy4, done4, err4, pc4});
        end
        reset = 1'b0;
        @(negedge clock);
        clear_q();
    endtask

    task automatic test_basic();
        int t, e, o;
        width = 32'd3; period = 32'd10; n_pulses = 16'd2;
        t = cyc;
        start = 1'b1;
        q_rise_exp.push_back(t + 1);  q_rise_exp.push_back(t + 11);
        q_fall_exp.push_back(t + 4);  q_fall_exp.push_back(t + 14);
        q_done_exp.push_back(t + 21);
        @(negedge clock);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_t1 got=%b exp=1", busy); end
        wait_to(t + 20);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_t20 got=%b exp=1", busy); end
        wait_to(t + 21);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL basic_end busy=%b done=%b exp busy=0 done=1", busy, done);
        end
        total++;
        if (pulse_count !== 16'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", pulse_count); end
        wait_to(t + 25);
        while (q_rise_exp.size() > 0) begin
            e = q_rise_exp.pop_front(); total++;
            o = (q_rise_obs.size() > 0) ? q_rise_obs.pop_front() : -1;
            if (o !== e) begin bad++; $display("FAIL basic_rise got=%0d exp=%0d", o, e); end
        end
        while (q_fall_exp.size() > 0) begin
            e = q_fall_exp.pop_front(); total++;
            o = (q_fall_obs.size() > 0) ? q_fall_obs.pop_front() : -1;
            if (o !== e) begin bad++; $display("FAIL basic_fall got=%0d exp=%0d", o, e); end
        end
        e = q_done_exp.pop_front(); total++;
        o = (q_done_obs.size() > 0) ? q_done_obs.pop_front() : -1;
        if (o !== e) begin bad++; $display("FAIL basic_done got=%0d exp=%0d", o, e); end
        total++;
        if (q_rise_obs.size() + q_done_obs.size() + q_err_obs.size() != 0) begin
            bad++; $display("FAIL basic_extra_events got=%0d exp=0",
                            q_rise_obs.size() + q_done_obs.size() + q_err_obs.size());
        end
        clear_q();
    endtask

    task automatic test_cfg_error();
        int t, e, o;
        logic [31:0] widths [2];
        logic [31:0] periods [2];
        widths[0] = 32'd0; periods[0] = 32'd5;
        widths[1] = 32'd5; periods[1] = 32'd5;
        for (int i = 0; i < 2; i++) begin
            width = widths[i]; period = periods[i]; n_pulses = 16'd1;
            t = cyc;
            start = 1'b1;
            q_err_exp.push_back(t + 1);
            @(negedge clock);
            start = 1'b0;
            total++;
            if (busy !== 1'b0 || fg_signal !== 1'b0) begin
                bad++; $display("FAIL cfg_idle[%0d] busy=%b fg=%b exp 0 0", i, busy, fg_signal);
            end
            total++;
            if (pulse_count !== 16'd2) begin
                bad++; $display("FAIL cfg_count[%0d] got=%0d exp=2", i, pulse_count);
            end
            wait_to(t + 5);
            e = q_err_exp.pop_front(); total++;
            o = (q_err_obs.size() > 0) ? q_err_obs.pop_front() : -1;
            if (o !== e) begin bad++; $display("FAIL cfg_err_cycle[%0d] got=%0d exp=%0d", i, o, e); end
            total++;
            if (q_err_obs.size() + q_rise_obs.size() + q_done_obs.size() != 0) begin
                bad++; $display("FAIL cfg_extra[%0d] got=%0d exp=0", i,
                                q_err_obs.size() + q_rise_obs.size() + q_done_obs.size());
            end
            clear_q();
        end
    endtask

    task automatic test_continuous_abort();
        int t, e, o;
        width = 32'd1; period = 32'd2; n_pulses = 16'd0;
        t = cyc;
        start = 1'b1;
        for (int k = 0; k < 10; k++) q_rise_exp.push_back(t + 1 + 2 * k);
        @(negedge clock);
        start = 1'b0;
        wait_to(t + 20);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        total++;
        if (fg_signal !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_stop fg=%b busy=%b exp 0 0", fg_signal, busy);
        end
        total++;
        if (pulse_count !== 16'd10) begin bad++; $display("FAIL abort_count got=%0d exp=10", pulse_count); end
        wait_to(t + 25);
        while (q_rise_exp.size() > 0) begin
            e = q_rise_exp.pop_front(); total++;
            o = (q_rise_obs.size() > 0) ? q_rise_obs.pop_front() : -1;
            if (o !== e) begin bad++; $display("FAIL cont_rise got=%0d exp=%0d", o, e); end
        end
        total++;
        if (q_rise_obs.size() + q_done_obs.size() != 0) begin
            bad++; $display("FAIL abort_no_done extra=%0d exp=0", q_rise_obs.size() + q_done_obs.size());
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int t, e, o;
        width = 32'd2; period = 32'd6; n_pulses = 16'd3;
        t = cyc;
        start = 1'b1;
        for (int k = 0; k < 3; k++) q_rise_exp.push_back(t + 1 + 6 * k);
        q_done_exp.push_back(t + 19);
        @(negedge clock);
        start = 1'b0;
        wait_to(t + 3);
        start = 1'b1; width = 32'd1; period = 32'd4; n_pulses = 16'd1;
        @(negedge clock);
        start = 1'b0;
        wait_to(t + 8);
        period = 32'd9;
        wait_to(t + 18);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_t18 got=%b exp=1", busy); end
        wait_to(t + 19);
        total++;
        if (busy !== 1'b0 || pulse_count !== 16'd3) begin
            bad++; $display("FAIL b2b_end busy=%b count=%0d exp busy=0 count=3", busy, pulse_count);
        end
        wait_to(t + 23);
        while (q_rise_exp.size() > 0) begin
            e = q_rise_exp.pop_front(); total++;
            o = (q_rise_obs.size() > 0) ? q_rise_obs.pop_front() : -1;
            if (o !== e) begin bad++; $display("FAIL b2b_rise got=%0d exp=%0d", o, e); end
        end
        e = q_done_exp.pop_front(); total++;
        o = (q_done_obs.size() > 0) ? q_done_obs.pop_front() : -1;
        if (o !== e) begin bad++; $display("FAIL b2b_done got=%0d exp=%0d", o, e); end
        total++;
        if (q_rise_obs.size() + q_done_obs.size() + q_err_obs.size() != 0) begin
            bad++; $display("FAIL b2b_extra got=%0d exp=0",
                            q_rise_obs.size() + q_done_obs.size() + q_err_obs.size());
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int t, e, o;
        width = 32'd4; period = 32'd10; n_pulses = 16'd3;
        t = cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_to(t + 12);
        total++;
        if (fg_signal !== 1'b1 || pulse_count !== 16'd2) begin
            bad++; $display("FAIL rst_pre fg=%b count=%0d exp fg=1 count=2", fg_signal, pulse_count);
        end
        reset = 1'b1; start = 1'b1; abort = 1'b0;
        @(negedge clock);
        total++;
        if ({fg_signal, busy, done, cfg_error} !== 4'b0000 || pulse_count !== 16'd0) begin
            bad++; $display("FAIL rst_mid flags=%b count=%0d exp flags=0000 count=0",
                            {fg_signal, busy, done, cfg_error}, pulse_count);
        end
        reset = 1'b0; start = 1'b0;
        clear_q();
        width = 32'd2; period = 32'd5; n_pulses = 16'd1;
        t = cyc;
        start = 1'b1;
        q_rise_exp.push_back(t + 1);
        q_done_exp.push_back(t + 6);
        @(negedge clock);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || pulse_count !== 16'd1) begin
            bad++; $display("FAIL rst_fresh busy=%b count=%0d exp busy=1 count=1", busy, pulse_count);
        end
        wait_to(t + 9);
        e = q_rise_exp.pop_front(); total++;
        o = (q_rise_obs.size() > 0) ? q_rise_obs.pop_front() : -1;
        if (o !== e) begin bad++; $display("FAIL rst_fresh_rise got=%0d exp=%0d", o, e); end
        e = q_done_exp.pop_front(); total++;
        o = (q_done_obs.size() > 0) ? q_done_obs.pop_front() : -1;
        if (o !== e) begin bad++; $display("FAIL rst_fresh_done got=%0d exp=%0d", o, e); end
        clear_q();
    endtask

    task automatic test_wrap();
        int t;
        width = 32'd1; period = 32'd2; n4 = 4'd0;
        t = cyc;
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        wait_to(t + 29);
        total++;
        if (pc4 !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", pc4); end
        wait_to(t + 31);
        total++;
        if (pc4 !== 4'd0 || fg4 !== 1'b1 || busy4 !== 1'b1) begin
            bad++; $display("FAIL wrap_0 count=%0d fg=%b busy=%b exp 0 1 1", pc4, fg4, busy4);
        end
        wait_to(t + 33);
        total++;
        if (pc4 !== 4'd1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
            bad++; $display("FAIL wrap_continue count=%0d busy=%b done=%b exp 1 1 0", pc4, busy4, done4);
        end
        wait_to(t + 34);
        abort4 = 1'b1;
        @(negedge clock);
        abort4 = 1'b0;
        total++;
        if (busy4 !== 1'b0 || fg4 !== 1'b0 || pc4 !== 4'd1) begin
            bad++; $display("FAIL wrap_abort busy=%b fg=%b count=%0d exp 0 0 1", busy4, fg4, pc4);
        end
        start4 = 1'b1; abort4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0; abort4 = 1'b0;
        total++;
        if (busy4 !== 1'b0 || fg4 !== 1'b0 || err4 !== 1'b0 || pc4 !== 4'd1) begin
            bad++; $display("FAIL start_abort busy=%b fg=%b err=%b count=%0d exp 0 0 0 1",
                            busy4, fg4, err4, pc4);
        end
        @(negedge clock);
        total++;
        if (busy4 !== 1'b0) begin bad++; $display("FAIL start_abort_late busy=%b exp=0", busy4); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_cfg_error();
        test_continuous_abort();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
